// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage of the RV32I pipeline.
// Holds the opcode/funct3 decode constants, the NOP encoding used for
// pipeline bubbles, the bus FSM state type and a misalignment helper.
package mem_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_t;

   // Halfwords need an even address, words need a word-aligned address.
   function automatic logic misaligned_access(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
      logic result;
      result = 1'b0;
      if (funct3[1:0] == 2'b01 && addr_lo[0])
         result = 1'b1;
      if (funct3[1:0] == 2'b10 && addr_lo != 2'b00)
         result = 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the memory stage and the memory.
// The master drives the request fields; the slave answers with ready and
// read data in the cycle the transfer completes.
interface mem_stage_if #(
   parameter int XLEN = 32
);

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_be,
      output dmem_wdata,
      input  dmem_ready,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_be,
      input  dmem_wdata,
      output dmem_ready,
      output dmem_rdata
   );

endinterface

// File: rtl/mem_load_align.sv
// Load data alignment for the memory stage.
// Picks the addressed byte/halfword/word out of the aligned read word and
// sign- or zero-extends it according to the load funct3.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Select the lane, then extend; unknown funct3 codes return the full word.
   always_comb begin
      sel_byte  = rdata[8*addr_lo +: 8];
      sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_data = {24'h000000, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_data = {16'h0000, sel_half};
         F3_W:    load_data = rdata;
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline.
// Issues loads/stores on the req/ready data bus, stalls the upstream
// stages while a transfer is outstanding, aborts requests that are not
// answered within TIMEOUT_CYCLES wait cycles, and registers MEM/WB.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned half/word
// accesses skip the bus and are flagged on misalign_wb instead.
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_mem,
   input  logic [XLEN-1:0] alu_mem,
   input  logic [XLEN-1:0] rs2_mem,
   input  logic [XLEN-1:0] instr_mem,
   input  logic [4:0]      rd_addr_mem,
   output logic [XLEN-1:0] forward_mem,
   output logic            mem_stall,
   mem_stage_if.master     dmem,
   output logic [XLEN-1:0] pc_wb,
   output logic [XLEN-1:0] alu_wb,
   output logic [XLEN-1:0] load_wb,
   output logic [XLEN-1:0] instr_wb,
   output logic [4:0]      rd_addr_wb,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic            misalign_wb,
`endif
   output logic            bus_err_wb
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_t  state, next_state;
   logic [7:0]  cnt, cnt_next;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load;
   logic        is_store;
   logic        mem_op;
   logic        bus_op;
   logic        misaligned;
   logic        timeout_abort;
   logic [31:0] aligned_load;

   assign opcode   = instr_mem[6:0];
   assign funct3   = instr_mem[14:12];
   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);
   assign mem_op   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = mem_op & misaligned_access(funct3, alu_mem[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   // Misaligned accesses (when trapped) never reach the bus.
   assign bus_op = mem_op & ~misaligned;

   assign forward_mem = alu_mem;

   // An unanswered request is dropped on the last allowed wait cycle.
   assign timeout_abort = (state == WAIT) & bus_op & ~dmem.dmem_ready &
                          (cnt == CNT_LAST);

   // Request and stall are forced low while reset is held.
   assign dmem.dmem_req = rst_n & bus_op;
   assign mem_stall     = rst_n & bus_op & ~dmem.dmem_ready & ~timeout_abort;

   assign dmem.dmem_addr = {alu_mem[XLEN-1:2], 2'b00};
   assign dmem.dmem_we   = is_store;

   // Store lanes and byte enables; loads read the whole word.
   always_comb begin
      dmem.dmem_be    = 4'hF;
      dmem.dmem_wdata = rs2_mem;
      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               dmem.dmem_be    = 4'b0001 << alu_mem[1:0];
               dmem.dmem_wdata = {4{rs2_mem[7:0]}};
            end
            2'b01: begin
               dmem.dmem_be    = 4'b0011 << {alu_mem[1], 1'b0};
               dmem.dmem_wdata = {2{rs2_mem[15:0]}};
            end
            default: begin
               dmem.dmem_be    = 4'hF;
               dmem.dmem_wdata = rs2_mem;
            end
         endcase
      end
   end

   // Bus FSM and wait counter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: wait for ready, count wait cycles, abort at the limit.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = 8'd0;
            if (bus_op && !dmem.dmem_ready)
               next_state = WAIT;
         end
         WAIT: begin
            if (!bus_op || dmem.dmem_ready || timeout_abort) begin
               next_state = IDLE;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: begin
            next_state = IDLE;
            cnt_next   = 8'd0;
         end
      endcase
   end

   mem_load_align u_load_align (
      .rdata     (dmem.dmem_rdata),
      .funct3    (funct3),
      .addr_lo   (alu_mem[1:0]),
      .load_data (aligned_load)
   );

   // MEM/WB registers: a bubble while stalled, otherwise capture the instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_wb       <= '0;
         alu_wb      <= '0;
         load_wb     <= '0;
         instr_wb    <= NOP_INSTR;
         rd_addr_wb  <= 5'd0;
         bus_err_wb  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_wb <= 1'b0;
`endif
      end else if (mem_stall) begin
         instr_wb    <= NOP_INSTR;
         rd_addr_wb  <= 5'd0;
         bus_err_wb  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_wb <= 1'b0;
`endif
      end else begin
         pc_wb       <= pc_mem;
         alu_wb      <= alu_mem;
         instr_wb    <= instr_mem;
         rd_addr_wb  <= rd_addr_mem;
         bus_err_wb  <= timeout_abort;
         load_wb     <= (is_load && !timeout_abort && !misaligned) ? aligned_load : '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_wb <= misaligned;
`endif
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: aligned loads, byte/half extension,
// store lanes, wait states, timeout abort, reset during a wait, and the
// optional MEM_MISALIGN_TRAP_EN behaviour when that macro is defined.
module tb_mem_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_mem, alu_mem, rs2_mem, instr_mem;
   logic [4:0]  rd_addr_mem;
   logic [31:0] forward_mem;
   logic        mem_stall;
   logic [31:0] pc_wb, alu_wb, load_wb, instr_wb;
   logic [4:0]  rd_addr_wb;
   logic        bus_err_wb;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_wb;
`endif

   int checks   = 0;
   int failures = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_mem      (pc_mem),
      .alu_mem     (alu_mem),
      .rs2_mem     (rs2_mem),
      .instr_mem   (instr_mem),
      .rd_addr_mem (rd_addr_mem),
      .forward_mem (forward_mem),
      .mem_stall   (mem_stall),
      .dmem        (bus.master),
      .pc_wb       (pc_wb),
      .alu_wb      (alu_wb),
      .load_wb     (load_wb),
      .instr_wb    (instr_wb),
      .rd_addr_wb  (rd_addr_wb),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_wb (misalign_wb),
`endif
      .bus_err_wb  (bus_err_wb)
   );

   always #5 clk = ~clk;

   // Builds an I/S-type style encoding with rs1=x1 and zero immediate.
   function automatic logic [31:0] mkInstr(input logic [6:0] opc,
                                           input logic [2:0] f3,
                                           input logic [4:0] rd);
      return {12'h000, 5'd1, f3, rd, opc};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [31:0] pc,
                                input logic [4:0] rd, input logic ready,
                                input logic [31:0] rdata);
      instr_mem      = instr;
      alu_mem        = alu;
      rs2_mem        = rs2;
      pc_mem         = pc;
      rd_addr_mem    = rd;
      bus.dmem_ready = ready;
      bus.dmem_rdata = rdata;
      #1;
   endtask

   initial begin
      int stall_cycles;
      logic [31:0] lw5, lw7, lb, lbu, sh, add;
      lw5 = mkInstr(OPC_LOAD, F3_W, 5'd5);
      lw7 = mkInstr(OPC_LOAD, F3_W, 5'd7);
      lb  = mkInstr(OPC_LOAD, F3_B, 5'd6);
      lbu = mkInstr(OPC_LOAD, F3_BU, 5'd6);
      sh  = mkInstr(OPC_STORE, F3_H, 5'd0);
      add = {7'd0, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011};

      // Reset with a load pending: bus and stall must stay quiet.
      rst_n = 1'b0;
      applyStimulus(lw5, 32'h100, 32'h0, 32'h40, 5'd5, 1'b0, 32'h0);
      checkOutput("rst_req", 32'(bus.dmem_req), 32'h0);
      checkOutput("rst_stall", 32'(mem_stall), 32'h0);
      step();
      step();
      checkOutput("rst_instr_wb", instr_wb, 32'h0000_0013);
      checkOutput("rst_pc_wb", pc_wb, 32'h0);
      checkOutput("rst_load_wb", load_wb, 32'h0);
      checkOutput("rst_rd_wb", 32'(rd_addr_wb), 32'h0);
      checkOutput("rst_buserr", 32'(bus_err_wb), 32'h0);
      rst_n = 1'b1;

      // LW x5 at 0x100, ready in the same cycle.
      applyStimulus(lw5, 32'h100, 32'h0, 32'h40, 5'd5, 1'b1, 32'hDEAD_BEEF);
      checkOutput("lw_stall", 32'(mem_stall), 32'h0);
      checkOutput("lw_req", 32'(bus.dmem_req), 32'h1);
      checkOutput("lw_we", 32'(bus.dmem_we), 32'h0);
      checkOutput("lw_be", 32'(bus.dmem_be), 32'hF);
      checkOutput("lw_addr", bus.dmem_addr, 32'h100);
      step();
      checkOutput("lw_load_wb", load_wb, 32'hDEAD_BEEF);
      checkOutput("lw_rd_wb", 32'(rd_addr_wb), 32'h5);
      checkOutput("lw_pc_wb", pc_wb, 32'h40);
      checkOutput("lw_instr_wb", instr_wb, lw5);

      // Byte loads from lane 3.
      applyStimulus(lb, 32'h103, 32'h0, 32'h44, 5'd6, 1'b1, 32'h80FF_0000);
      checkOutput("lb_addr", bus.dmem_addr, 32'h100);
      step();
      checkOutput("lb_load_wb", load_wb, 32'hFFFF_FF80);
      applyStimulus(lbu, 32'h103, 32'h0, 32'h48, 5'd6, 1'b1, 32'h80FF_0000);
      step();
      checkOutput("lbu_load_wb", load_wb, 32'h0000_0080);

      // Halfword store to the upper half.
      applyStimulus(sh, 32'h202, 32'h1234_ABCD, 32'h4C, 5'd0, 1'b1, 32'h0);
      checkOutput("sh_be", 32'(bus.dmem_be), 32'hC);
      checkOutput("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
      checkOutput("sh_addr", bus.dmem_addr, 32'h200);
      checkOutput("sh_we", 32'(bus.dmem_we), 32'h1);
      step();
      checkOutput("sh_load_wb", load_wb, 32'h0);

      // LW answered after three cycles: three bubbles, stable request.
      applyStimulus(lw5, 32'h104, 32'h0, 32'h50, 5'd5, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("wait_stall", 32'(mem_stall), 32'h1);
         checkOutput("wait_req", 32'(bus.dmem_req), 32'h1);
         checkOutput("wait_addr", bus.dmem_addr, 32'h104);
         checkOutput("wait_be", 32'(bus.dmem_be), 32'hF);
         step();
         checkOutput("bubble_instr", instr_wb, 32'h0000_0013);
         checkOutput("bubble_rd", 32'(rd_addr_wb), 32'h0);
      end
      bus.dmem_ready = 1'b1;
      bus.dmem_rdata = 32'hCAFE_F00D;
      #1;
      checkOutput("wait_done_stall", 32'(mem_stall), 32'h0);
      step();
      checkOutput("wait_load_wb", load_wb, 32'hCAFE_F00D);
      checkOutput("wait_rd_wb", 32'(rd_addr_wb), 32'h5);

      // Request never answered: abort after the timeout.
      applyStimulus(lw7, 32'h108, 32'h0, 32'h54, 5'd7, 1'b0, 32'h1234_5678);
      stall_cycles = 0;
      while (mem_stall && stall_cycles < 300) begin
         stall_cycles++;
         step();
      end
      checkOutput("to_stall_cycles", 32'(stall_cycles), 32'd255);
      checkOutput("to_abort_req", 32'(bus.dmem_req), 32'h1);
      step();
      checkOutput("to_buserr", 32'(bus_err_wb), 32'h1);
      checkOutput("to_load_wb", load_wb, 32'h0);
      checkOutput("to_rd_wb", 32'(rd_addr_wb), 32'h7);
      checkOutput("to_instr_wb", instr_wb, lw7);

      // Non-memory op: no bus activity, forwarding follows the ALU.
      applyStimulus(add, 32'h55, 32'h0, 32'h58, 5'd9, 1'b0, 32'h0);
      checkOutput("add_req", 32'(bus.dmem_req), 32'h0);
      checkOutput("add_fwd", forward_mem, 32'h55);
      checkOutput("add_stall", 32'(mem_stall), 32'h0);
      step();
      checkOutput("add_buserr", 32'(bus_err_wb), 32'h0);
      checkOutput("add_alu_wb", alu_wb, 32'h55);

      // Reset while waiting: request dropped at once, WB back to reset values.
      applyStimulus(lw5, 32'h10C, 32'h0, 32'h5C, 5'd5, 1'b0, 32'h0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      checkOutput("rstw_req", 32'(bus.dmem_req), 32'h0);
      checkOutput("rstw_stall", 32'(mem_stall), 32'h0);
      step();
      checkOutput("rstw_instr_wb", instr_wb, 32'h0000_0013);
      checkOutput("rstw_pc_wb", pc_wb, 32'h0);
      rst_n = 1'b1;
      applyStimulus(lw5, 32'h10C, 32'h0, 32'h60, 5'd5, 1'b1, 32'h1122_3344);
      checkOutput("rstw_after_stall", 32'(mem_stall), 32'h0);
      step();
      checkOutput("rstw_after_load", load_wb, 32'h1122_3344);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned word load is trapped instead of issued.
      applyStimulus(lw5, 32'h101, 32'h0, 32'h64, 5'd5, 1'b0, 32'hFFFF_FFFF);
      checkOutput("mis_req", 32'(bus.dmem_req), 32'h0);
      checkOutput("mis_stall", 32'(mem_stall), 32'h0);
      step();
      checkOutput("mis_flag", 32'(misalign_wb), 32'h1);
      checkOutput("mis_load_wb", load_wb, 32'h0);
`else
      // Odd halfword address: low bit dropped, upper half sign-extended.
      applyStimulus(mkInstr(OPC_LOAD, F3_H, 5'd3), 32'h203, 32'h0, 32'h64, 5'd3,
                    1'b1, 32'h8001_0000);
      checkOutput("lh_odd_req", 32'(bus.dmem_req), 32'h1);
      step();
      checkOutput("lh_odd_load_wb", load_wb, 32'hFFFF_8001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
